// File: rtl/lpc_decode_control_if.sv
// lpc_decode_control_if: control/handshake bundle between the LPC decode sequencer and its datapath
interface lpc_decode_control_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              ready_synth;
  logic              rack;
  logic [ADDR_W-1:0] coef_addr;
  logic              coef_load;
  logic [ADDR_W-1:0] coef_idx;
  logic              reset_synth;
  logic [1:0]        a_rsel_sel;
  logic              e_raddr_sel;
  logic              rready;
  logic              busy;
  logic              error;
  logic [7:0]        frame_count;
  modport slave (
    input  start, ready_synth, rack,
    output coef_addr, coef_load, coef_idx, reset_synth, a_rsel_sel, e_raddr_sel,
           rready, busy, error, frame_count
  );
  modport master (
    output start, ready_synth, rack,
    input  coef_addr, coef_load, coef_idx, reset_synth, a_rsel_sel, e_raddr_sel,
           rready, busy, error, frame_count
  );
endinterface

// File: rtl/lpc_decode_control.sv
// lpc_decode_control: LPC synthesis sequencer; define LPC_DEC_TIMEOUT_EN to add the S_RUN watchdog
module lpc_decode_control #(
  parameter int ORDER     = 10,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT_W = 16
) (
  input logic clk,
  input logic reset,
  lpc_decode_control_if.slave bus
);
  localparam int KW = ADDR_W + 1;
  if (ORDER < 2 || ORDER > (1 << ADDR_W) || TIMEOUT_W < 1) begin : g_bad_params
    $error("lpc_decode_control: illegal ORDER/ADDR_W/TIMEOUT_W");
  end
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_START = 3'd2, S_RUN = 3'd3, S_DONE = 3'd4} state_e;
  state_e      state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]  frame_q, frame_d;
  logic        busy_q, error_q, error_d;
  logic        tmo_hit;
`ifdef LPC_DEC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  // held at zero outside S_RUN so it is already clear on entry
  assign tmo_d   = (state_q == S_RUN) ? tmo_q + TIMEOUT_W'(1) : '0;
  assign tmo_hit = (state_q == S_RUN) && (&tmo_d);
  always_ff @(posedge clk) tmo_q <= reset ? '0 : tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    frame_d          = frame_q;
    error_d          = error_q;
    bus.coef_addr    = '0;
    bus.coef_load    = 1'b0;
    bus.coef_idx     = '0;
    bus.reset_synth  = 1'b0;
    bus.a_rsel_sel   = 2'd2;
    bus.e_raddr_sel  = 1'b0;
    bus.rready       = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_LOAD;
        k_d     = '0;
        error_d = 1'b0;
      end
      S_LOAD: begin
        // memory read latency of one cycle: bank write trails the address by one
        bus.a_rsel_sel = 2'd0;
        bus.coef_addr  = (k_q >= KW'(ORDER - 1)) ? ADDR_W'(ORDER - 1) : k_q[ADDR_W-1:0];
        bus.coef_load  = (k_q != '0);
        bus.coef_idx   = k_q[ADDR_W-1:0] - ADDR_W'(1);
        k_d            = k_q + KW'(1);
        state_d        = (k_q == KW'(ORDER)) ? S_START : S_LOAD;
      end
      S_START: begin
        bus.reset_synth = 1'b1;
        bus.a_rsel_sel  = 2'd1;
        bus.e_raddr_sel = 1'b1;
        state_d         = S_RUN;
      end
      S_RUN: begin
        bus.a_rsel_sel  = 2'd1;
        bus.e_raddr_sel = 1'b1;
        if (bus.ready_synth || tmo_hit) begin
          state_d = S_DONE;
          frame_d = frame_q + 8'd1;
          error_d = ~bus.ready_synth;
        end
      end
      S_DONE: begin
        bus.rready = 1'b1;
        state_d    = bus.rack ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      frame_q <= frame_d;
      busy_q  <= (state_d != S_IDLE);
      error_q <= error_d;
    end
  end
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;
  assign bus.frame_count = frame_q;
endmodule
